// File: rtl/memory_access_if.sv
// Data-bus bundle between the memory-stage controller and the data memory.
interface memory_access_if #(
    parameter int XLEN = 64
);
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [1:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic            dresp_addr_ok;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_access.sv
// Memory-stage access controller: issues one data-bus transaction per
// load/store, aligns store data, extends load data and stalls the front of
// the pipeline until the access completes.
module memory_access #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       msize,
    input  logic             mem_unsigned,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    input  logic             advance,
    memory_access_if.master  bus,
    output logic [XLEN-1:0]  rdata,
    output logic             stall,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            mem_op;
    logic            bad_align;
    logic            aligned_op;
    logic            req_active;
    logic            capture;
    logic [2:0]      off;
    logic [5:0]      shamt;
    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] rdata_q;
    logic            unused_addr_ok;

    // Address acceptance is informational only; the request is held until data_ok.
    assign unused_addr_ok = bus.dresp_addr_ok;

    assign mem_op     = in_valid & (mem_read | mem_write);
    assign off        = addr[2:0];
    assign shamt      = {off, 3'b000};
    assign aligned_op = mem_op & ~bad_align;
    assign misaligned = mem_op & bad_align;

    // Size-alignment check and per-size byte mask
    always_comb begin
        bad_align = 1'b0;
        base_mask = 8'h01;
        unique case (msize)
            2'b00: begin bad_align = 1'b0;            base_mask = 8'h01; end
            2'b01: begin bad_align = addr[0];         base_mask = 8'h03; end
            2'b10: begin bad_align = |addr[1:0];      base_mask = 8'h0F; end
            2'b11: begin bad_align = |addr[2:0];      base_mask = 8'hFF; end
            default: begin bad_align = 1'b0;          base_mask = 8'h01; end
        endcase
    end

    assign bus.dreq_addr   = addr;
    assign bus.dreq_size   = msize;
    assign bus.dreq_strobe = mem_write ? (base_mask << off) : '0;
    assign bus.dreq_data   = wdata << shamt;

    // Pick the addressed lane out of the raw doubleword and extend it
    always_comb begin
        shifted  = bus.dresp_data >> shamt;
        load_ext = shifted;
        unique case (msize)
            2'b00: load_ext = mem_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                           : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = mem_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'b10: load_ext = mem_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                           : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            2'b11: load_ext = shifted;
            default: load_ext = shifted;
        endcase
    end

    // Next-state and request-active decode
    always_comb begin
        state_next = state;
        req_active = 1'b0;
        unique case (state)
            IDLE: begin
                if (aligned_op) begin
                    req_active = 1'b1;
                    state_next = bus.dresp_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                req_active = 1'b1;
                if (bus.dresp_data_ok) state_next = DONE;
            end
            DONE: begin
                if (advance) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces the bus request and stall low even before the flops clear
    assign bus.dreq_valid = req_active & ~reset;
    assign stall          = aligned_op & (state != DONE) & ~reset;
    assign capture        = req_active & bus.dresp_data_ok & mem_read;
    assign rdata          = rdata_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Load result holding register; stores leave it untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        rdata_q <= '0;
        else if (capture) rdata_q <= load_ext;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-stage access controller of the five-stage pipeline, fed directly by the E→M pipeline register. It turns a load or store held in that register into a data-bus transaction, aligns and byte-enables store data, and sign- or zero-extends load data. It raises `stall` so the hazard unit freezes the E→M register while the access is outstanding, and holds the completed result until the M→W register takes it.

## Interface
- `XLEN`, 64, datapath and address width. Only 64 is supported.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high; all state clears immediately on assertion.
- `in_valid`  in  1  the E→M register holds a valid instruction.
- `mem_read`  in  1  the instruction is a load.
- `mem_write`  in  1  the instruction is a store. Never asserted together with `mem_read`.
- `msize`  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- `mem_unsigned`  in  1  zero-extend the load result; otherwise sign-extend.
- `addr`  in  XLEN  effective byte address.
- `wdata`  in  XLEN  store data, right-aligned.
- `advance`  in  1  the M→W register loads this cycle.
- `dreq_valid`  out  1  data-bus request valid.
- `dreq_addr`  out  XLEN  equals `addr`.
- `dreq_size`  out  2  equals `msize`.
- `dreq_strobe`  out  8  byte write enables. Always 0 for loads.
- `dreq_data`  out  XLEN  lane-aligned store data.
- `dresp_addr_ok`  in  1  address accepted. Monitored only.
- `dresp_data_ok`  in  1  transaction complete.
- `dresp_data`  in  XLEN  raw 8-byte-aligned read data.
- `rdata`  out  XLEN  extended load result.
- `stall`  out  1  freeze the E→M register and every earlier stage.
- `misaligned`  out  1  the memory op address is not size-aligned.

## Operation
- A memory op is defined as `in_valid & (mem_read | mem_write)`.
- The op is misaligned when any of the following holds:
  - half with `addr[0]` set;
  - word with `addr[1:0]` nonzero;
  - double with `addr[2:0]` nonzero.
- A misaligned op issues no request, raises no `stall`, and asserts `misaligned` combinationally.
- Let `off = addr[2:0]`.
- Store strobe is the base mask shifted left by `off`. Base masks: byte 0x01, half 0x03, word 0x0F, double 0xFF.
- Store data is `wdata << (8*off)`. Bits shifted past bit 63 are dropped.
- Load path:
  - shift `dresp_data` right by `8*off`;
  - keep the low 8/16/32/64 bits per `msize`;
  - extend per `mem_unsigned`;
  - capture the result into `rdata_q` on `dresp_data_ok`.
- State machine `state`, reset value IDLE:
  - IDLE: for an aligned memory op, `dreq_valid`=1.
    - `dresp_data_ok`=1 in the same cycle → DONE.
    - Otherwise → WAIT.
  - WAIT: `dreq_valid`=1, request fields unchanged. On `dresp_data_ok` → DONE.
  - DONE: `dreq_valid`=0, `stall`=0, `rdata`=`rdata_q`. On `advance` → IDLE; otherwise stay in DONE. Staying prevents a repeated access when a later stage stalls the pipeline.
- `stall = aligned memory op & state != DONE`.
- Non-memory ops pass with `stall`=0 and `dreq_valid`=0. `rdata` shows `rdata_q` and has no meaning for these ops.
- A store also goes to DONE on `dresp_data_ok`. `rdata_q` is left unchanged.
- Upstream must hold every input stable while `stall`=1; that is the point of the stall. Input changes in WAIT are undefined behaviour.
- `dresp_addr_ok` does not affect state. The request stays asserted until `dresp_data_ok`.

## Timing
- Combinational paths in the same cycle:
  - from inputs: `dreq_*`, `stall`, `misaligned`;
  - `rdata` reflects registered `rdata_q`.
- Best case: the op arrives in cycle 0 with `dresp_data_ok` in cycle 0. `stall` is high in cycle 0, low in cycle 1 with `rdata` valid. One bubble.
- N-cycle bus latency: `stall` is high for N+1 cycles.
- Reset values:
  - `state`=IDLE, `rdata_q`=0;
  - `dreq_valid`=0 and `stall`=0 while `reset` is high, regardless of inputs.
- Reset in WAIT abandons the transaction. The bus is reset by the same signal.
- `advance`=0 in DONE: state holds, `rdata` holds, `dreq_valid`=0.
- `dresp_data_ok` while in IDLE with no request outstanding is ignored.

## Test plan
- Aligned LD, `addr`=0x80000008, `dresp_data`=0x1122334455667788 with `data_ok` after 2 cycles:
  - `stall` high 3 cycles;
  - then `rdata`=0x1122334455667788;
  - `dreq_strobe`=0.
- LB signed, `addr`=0x...3, `dresp_data` byte 3 = 0x80 → `rdata`=0xFFFFFFFFFFFFFF80. Same access as LBU → 0x80.
- SH, `addr`=0x...6, `wdata`=0xABCD:
  - `dreq_strobe`=0xC0;
  - `dreq_data`=0xABCD000000000000;
  - DONE with `rdata` unchanged.
- LW at `addr`=0x...2:
  - `misaligned`=1, `dreq_valid`=0, `stall`=0 in the same cycle.
- Load completes while `advance`=0 for 3 cycles:
  - exactly one `dreq_valid` transaction;
  - `rdata` stable;
  - return to IDLE in the cycle after `advance`.
- Assert `reset` in WAIT:
  - `dreq_valid` and `stall` drop in the same cycle;
  - after release, state is IDLE and `rdata`=0.
